// File: rtl/cell_color_scheduler_if.sv
// cell_color_scheduler_if: keys, switches, scan position and colour/cursor outputs of the cell colour scheduler
interface cell_color_scheduler_if;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [2:0] HCState;
  logic [2:0] VCState;
  logic [1:0] VState;
  logic       R;
  logic       G;
  logic       B;
  logic       Busy;
  logic [2:0] CurX;
  logic [2:0] CurY;
  modport master (output KEY, SW, HCState, VCState, VState, input R, G, B, Busy, CurX, CurY);
  modport slave (input KEY, SW, HCState, VCState, VState, output R, G, B, Busy, CurX, CurY);
endinterface

// File: rtl/cell_color_scheduler.sv
// cell_color_scheduler: 8x8 cell colour memory with debounced keys, cursor, blanking-deferred writes/clear and blinking cursor overlay (ports: CLK, Reset, bus slave: KEY/SW/HCState/VCState/VState in, R/G/B/Busy/CurX/CurY out)
module cell_color_scheduler #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLINK_FRAMES = 30
) (
  input logic CLK,
  input logic Reset,
  cell_color_scheduler_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [1:0] IDLE = 2'd0, PEND_WR = 2'd1, CLEAR = 2'd2;
  logic [3:0] s1, s2, rel, pulse;
  logic [CW-1:0] cnt [4];
  logic [2:0] cur_x, cur_y, wr_col, rgb;
  logic [2:0] mem [64];
  logic [1:0] state, vprev;
  logic [5:0] idx, wr_addr;
  logic [FW-1:0] fc;
  logic blink, blank, tick, ov, fwrap;
  logic unused_sw;
  assign unused_sw = ^bus.SW[9:3];
  // rel=1: armed, waiting for a stable low; rel=0: pressed, waiting for a stable high
  always_ff @(posedge CLK)
    if (Reset) begin
      s1 <= '1;
      s2 <= '1;
      rel <= '1;
      pulse <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      s1 <= bus.KEY;
      s2 <= s1;
      pulse <= '0;
      for (int k = 0; k < 4; k++)
        if (s2[k] != rel[k]) begin
          cnt[k] <= cnt[k] + 1'b1;
          if (cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt[k] <= '0;
            rel[k] <= ~rel[k];
            pulse[k] <= rel[k];
          end
        end else cnt[k] <= '0;
    end
  // right carries into the row on column wrap, then down adds on top
  always_ff @(posedge CLK)
    if (Reset) begin
      cur_x <= '0;
      cur_y <= '0;
    end else begin
      cur_x <= cur_x + 3'(pulse[1]);
      cur_y <= cur_y + 3'(pulse[1] && cur_x == 3'd7) + 3'(pulse[2]);
    end
  assign blank = bus.VState != 2'd2;
  always_ff @(posedge CLK)
    if (Reset) begin
      state <= IDLE;
      idx <= '0;
      wr_col <= '0;
      wr_addr <= '0;
      for (int a = 0; a < 64; a++) mem[a] <= '0;
    end else if (state == IDLE) begin
      if (pulse[3]) begin
        state <= CLEAR;
        idx <= '0;
      end else if (pulse[0]) begin
        state <= PEND_WR;
        wr_col <= bus.SW[2:0];
        wr_addr <= {cur_y, cur_x};
      end
    end else if (blank) begin
      mem[state == CLEAR ? idx : wr_addr] <= state == CLEAR ? 3'd0 : wr_col;
      idx <= idx + 1'b1;
      if (state != CLEAR || idx == 6'd63) state <= IDLE;
    end
  assign tick = vprev == 2'd2 && blank;
  assign fwrap = fc == FW'(BLINK_FRAMES - 1);
  always_ff @(posedge CLK)
    if (Reset) begin
      vprev <= '0;
      fc <= '0;
      blink <= 1'b0;
    end else begin
      vprev <= bus.VState;
      if (tick) begin
        fc <= fwrap ? '0 : fc + 1'b1;
        blink <= blink ^ fwrap;
      end
    end
  assign ov = blink && bus.HCState == cur_x && bus.VCState == cur_y;
  always_ff @(posedge CLK)
    if (Reset) rgb <= '0;
    else rgb <= mem[{bus.VCState, bus.HCState}] ^ {3{ov}};
  assign {bus.R, bus.G, bus.B} = rgb;
  assign bus.Busy = state != IDLE;
  assign bus.CurX = cur_x;
  assign bus.CurY = cur_y;
endmodule
